// File: rtl/demux_1x2_stream_ctrl.sv
// Packet-aware 1-to-2 stream demultiplexer: steers each packet to one port
// (by destination bit or round-robin), one registered output stage, per-port packet counters.
module demux_1x2_stream_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             MODE,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_VALID,
    input  logic             IN_LAST,
    input  logic             IN_DEST,
    output logic             IN_READY,
    output logic [WIDTH-1:0] OUT0_DATA,
    output logic             OUT0_VALID,
    output logic             OUT0_LAST,
    input  logic             OUT0_READY,
    output logic [WIDTH-1:0] OUT1_DATA,
    output logic             OUT1_VALID,
    output logic             OUT1_LAST,
    input  logic             OUT1_READY,
    output logic             BUSY,
    output logic [CNT_W-1:0] PKT_CNT0,
    output logic [CNT_W-1:0] PKT_CNT1
);

    typedef enum logic [0:0] {
        ST_SOP = 1'b0,
        ST_MID = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nxt_s;
    logic             rr_ptr_r;
    logic             rr_ptr_nxt_s;
    logic             lock_port_r;
    logic             lock_port_nxt_s;
    logic             lock_rr_r;
    logic             lock_rr_nxt_s;

    // The output stage is the per-port output registers themselves; at most one port is valid.
    logic [WIDTH-1:0] out0_data_r;
    logic             out0_valid_r;
    logic             out0_last_r;
    logic [WIDTH-1:0] out1_data_r;
    logic             out1_valid_r;
    logic             out1_last_r;
    logic [WIDTH-1:0] out0_data_nxt_s;
    logic             out0_valid_nxt_s;
    logic             out0_last_nxt_s;
    logic [WIDTH-1:0] out1_data_nxt_s;
    logic             out1_valid_nxt_s;
    logic             out1_last_nxt_s;

    logic             busy_r;
    logic             busy_nxt_s;
    logic [CNT_W-1:0] cnt0_r;
    logic [CNT_W-1:0] cnt1_r;
    logic [CNT_W-1:0] cnt0_nxt_s;
    logic [CNT_W-1:0] cnt1_nxt_s;

    logic             buf_valid_s;
    logic             deliver0_s;
    logic             deliver1_s;
    logic             deliver_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             route_port_s;
    logic             route_rr_s;

    assign buf_valid_s = out0_valid_r | out1_valid_r;
    assign deliver0_s  = out0_valid_r & OUT0_READY;
    assign deliver1_s  = out1_valid_r & OUT1_READY;
    assign deliver_s   = deliver0_s | deliver1_s;
    assign in_ready_s  = ~buf_valid_s | deliver_s;
    assign accept_s    = IN_VALID & in_ready_s;

    // Destination of the current beat: decided at SOP, locked for the rest of the packet.
    always_comb begin
        route_port_s = lock_port_r;
        route_rr_s   = lock_rr_r;
        if (state_r == ST_SOP) begin
            route_port_s = MODE ? rr_ptr_r : IN_DEST;
            route_rr_s   = MODE;
        end else begin
            route_port_s = lock_port_r;
            route_rr_s   = lock_rr_r;
        end
    end

    // Packet state machine, port lock and round-robin pointer next-state.
    always_comb begin
        state_nxt_s     = state_r;
        lock_port_nxt_s = lock_port_r;
        lock_rr_nxt_s   = lock_rr_r;
        rr_ptr_nxt_s    = rr_ptr_r;
        if (accept_s) begin
            case (state_r)
                ST_SOP: begin
                    lock_port_nxt_s = route_port_s;
                    lock_rr_nxt_s   = MODE;
                    state_nxt_s     = IN_LAST ? ST_SOP : ST_MID;
                end
                ST_MID: begin
                    state_nxt_s = IN_LAST ? ST_SOP : ST_MID;
                end
                default: begin
                    state_nxt_s = ST_SOP;
                end
            endcase
            // Only packets steered by round-robin advance the pointer.
            if (IN_LAST && route_rr_s) begin
                rr_ptr_nxt_s = ~rr_ptr_r;
            end else begin
                rr_ptr_nxt_s = rr_ptr_r;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Output stage next-state: load on accept, drain on delivery, otherwise hold.
    always_comb begin
        out0_data_nxt_s  = out0_data_r;
        out0_valid_nxt_s = out0_valid_r;
        out0_last_nxt_s  = out0_last_r;
        out1_data_nxt_s  = out1_data_r;
        out1_valid_nxt_s = out1_valid_r;
        out1_last_nxt_s  = out1_last_r;
        if (accept_s) begin
            out0_valid_nxt_s = ~route_port_s;
            out0_last_nxt_s  = ~route_port_s & IN_LAST;
            out0_data_nxt_s  = route_port_s ? {WIDTH{1'b0}} : IN_DATA;
            out1_valid_nxt_s = route_port_s;
            out1_last_nxt_s  = route_port_s & IN_LAST;
            out1_data_nxt_s  = route_port_s ? IN_DATA : {WIDTH{1'b0}};
        end else if (deliver_s) begin
            out0_valid_nxt_s = 1'b0;
            out0_last_nxt_s  = 1'b0;
            out0_data_nxt_s  = {WIDTH{1'b0}};
            out1_valid_nxt_s = 1'b0;
            out1_last_nxt_s  = 1'b0;
            out1_data_nxt_s  = {WIDTH{1'b0}};
        end else begin
            out0_valid_nxt_s = out0_valid_r;
            out1_valid_nxt_s = out1_valid_r;
        end
    end

    // Packet counters and the registered busy flag.
    always_comb begin
        cnt0_nxt_s = cnt0_r;
        cnt1_nxt_s = cnt1_r;
        if (deliver0_s && out0_last_r) begin
            cnt0_nxt_s = cnt0_r + CNT_ONE;
        end else begin
            cnt0_nxt_s = cnt0_r;
        end
        if (deliver1_s && out1_last_r) begin
            cnt1_nxt_s = cnt1_r + CNT_ONE;
        end else begin
            cnt1_nxt_s = cnt1_r;
        end
        busy_nxt_s = (state_nxt_s == ST_MID) | out0_valid_nxt_s | out1_valid_nxt_s;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= ST_SOP;
            rr_ptr_r     <= 1'b0;
            lock_port_r  <= 1'b0;
            lock_rr_r    <= 1'b0;
            out0_data_r  <= {WIDTH{1'b0}};
            out0_valid_r <= 1'b0;
            out0_last_r  <= 1'b0;
            out1_data_r  <= {WIDTH{1'b0}};
            out1_valid_r <= 1'b0;
            out1_last_r  <= 1'b0;
            busy_r       <= 1'b0;
            cnt0_r       <= {CNT_W{1'b0}};
            cnt1_r       <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            rr_ptr_r     <= rr_ptr_nxt_s;
            lock_port_r  <= lock_port_nxt_s;
            lock_rr_r    <= lock_rr_nxt_s;
            out0_data_r  <= out0_data_nxt_s;
            out0_valid_r <= out0_valid_nxt_s;
            out0_last_r  <= out0_last_nxt_s;
            out1_data_r  <= out1_data_nxt_s;
            out1_valid_r <= out1_valid_nxt_s;
            out1_last_r  <= out1_last_nxt_s;
            busy_r       <= busy_nxt_s;
            cnt0_r       <= cnt0_nxt_s;
            cnt1_r       <= cnt1_nxt_s;
        end
    end

    assign IN_READY   = in_ready_s;
    assign OUT0_DATA  = out0_data_r;
    assign OUT0_VALID = out0_valid_r;
    assign OUT0_LAST  = out0_last_r;
    assign OUT1_DATA  = out1_data_r;
    assign OUT1_VALID = out1_valid_r;
    assign OUT1_LAST  = out1_last_r;
    assign BUSY       = busy_r;
    assign PKT_CNT0   = cnt0_r;
    assign PKT_CNT1   = cnt1_r;

endmodule

// File: tb/tb_demux_1x2_stream_ctrl.sv
// Scoreboard bench for demux_1x2_stream_ctrl: directed packets push expected beats per port,
// a negedge monitor pops and compares every delivered beat.
module tb_demux_1x2_stream_ctrl;

    typedef struct packed {
        logic       last;
        logic [3:0] data;
    } beat_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       MODE = 1'b0;
    logic [3:0] IN_DATA = 4'h0;
    logic       IN_VALID = 1'b0;
    logic       IN_LAST = 1'b0;
    logic       IN_DEST = 1'b0;
    logic       IN_READY;
    logic [3:0] OUT0_DATA;
    logic       OUT0_VALID;
    logic       OUT0_LAST;
    logic       OUT0_READY = 1'b1;
    logic [3:0] OUT1_DATA;
    logic       OUT1_VALID;
    logic       OUT1_LAST;
    logic       OUT1_READY = 1'b1;
    logic       BUSY;
    logic [7:0] PKT_CNT0;
    logic [7:0] PKT_CNT1;

    beat_t q0[$];
    beat_t q1[$];
    int    total = 0;
    int    bad = 0;

    demux_1x2_stream_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST), .MODE(MODE),
        .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_LAST(IN_LAST), .IN_DEST(IN_DEST),
        .IN_READY(IN_READY),
        .OUT0_DATA(OUT0_DATA), .OUT0_VALID(OUT0_VALID), .OUT0_LAST(OUT0_LAST),
        .OUT0_READY(OUT0_READY),
        .OUT1_DATA(OUT1_DATA), .OUT1_VALID(OUT1_VALID), .OUT1_LAST(OUT1_LAST),
        .OUT1_READY(OUT1_READY),
        .BUSY(BUSY), .PKT_CNT0(PKT_CNT0), .PKT_CNT1(PKT_CNT1)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Offer one beat, wait (bounded) for IN_READY, record where it must come out.
    task automatic send(input logic [3:0] d, input logic last, input logic dest,
                        input logic mode, input logic port);
        int n;
        beat_t b;
        @(negedge CLK);
        MODE = mode; IN_DATA = d; IN_LAST = last; IN_DEST = dest; IN_VALID = 1'b1;
        #1;
        n = 0;
        while (!IN_READY && n < 100) begin
            @(negedge CLK);
            #1;
            n++;
        end
        if (!IN_READY) begin
            check("send_ready_timeout", 0, 1);
            IN_VALID = 1'b0;
        end else begin
            b.last = last;
            b.data = d;
            if (port) q1.push_back(b);
            else q0.push_back(b);
            @(posedge CLK);
            #1;
            IN_VALID = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge CLK);
        IN_VALID = 1'b0;
        while ((q0.size() != 0 || q1.size() != 0 || BUSY) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("drain_timeout", int'(n >= 200), 0);
        #4;
    endtask

    task automatic check_counts(input string name, input int c0, input int c1);
        check({name, "_cnt0"}, int'(PKT_CNT0), c0);
        check({name, "_cnt1"}, int'(PKT_CNT1), c1);
    endtask

    task automatic check_idle(input string name);
        check({name, "_out0"}, int'({OUT0_VALID, OUT0_LAST, OUT0_DATA}), 0);
        check({name, "_out1"}, int'({OUT1_VALID, OUT1_LAST, OUT1_DATA}), 0);
        check({name, "_in_ready"}, int'(IN_READY), 1);
        check({name, "_busy"}, int'(BUSY), 0);
        check_counts(name, 0, 0);
    endtask

    // Scoreboard monitor: compare each delivered beat, and zeros on idle ports.
    always @(negedge CLK) begin
        beat_t e;
        #3;
        if (!RST) begin
            if (OUT0_VALID && OUT0_READY) begin
                if (q0.size() == 0) begin
                    total++; bad++;
                    $display("FAIL out0_unexpected: got data %0d want no beat", OUT0_DATA);
                end else begin
                    e = q0.pop_front();
                    check("out0_data", int'(OUT0_DATA), int'(e.data));
                    check("out0_last", int'(OUT0_LAST), int'(e.last));
                end
            end
            if (OUT1_VALID && OUT1_READY) begin
                if (q1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL out1_unexpected: got data %0d want no beat", OUT1_DATA);
                end else begin
                    e = q1.pop_front();
                    check("out1_data", int'(OUT1_DATA), int'(e.data));
                    check("out1_last", int'(OUT1_LAST), int'(e.last));
                end
            end
            if (!OUT0_VALID) check("out0_idle_zero", int'({OUT0_LAST, OUT0_DATA}), 0);
            if (!OUT1_VALID) check("out1_idle_zero", int'({OUT1_LAST, OUT1_DATA}), 0);
            check("both_valid", int'(OUT0_VALID && OUT1_VALID), 0);
        end
    end

    initial begin
        // Reset then idle.
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #2;
        check_idle("reset");

        // Destination routing, 3-beat packet to port 1.
        send(4'h3, 1'b0, 1'b1, 1'b0, 1'b1);
        send(4'h5, 1'b0, 1'b1, 1'b0, 1'b1);
        send(4'h9, 1'b1, 1'b1, 1'b0, 1'b1);
        drain();
        check_counts("dest", 0, 1);

        // IN_DEST changes mid-packet and must be ignored.
        send(4'h6, 1'b0, 1'b0, 1'b0, 1'b0);
        send(4'h7, 1'b1, 1'b1, 1'b0, 1'b0);
        drain();
        check_counts("dest_lock", 1, 1);

        // Round-robin on single-beat packets, pointer starts at 0.
        send(4'hA, 1'b1, 1'b1, 1'b1, 1'b0);
        send(4'hB, 1'b1, 1'b0, 1'b1, 1'b1);
        send(4'hC, 1'b1, 1'b1, 1'b1, 1'b0);
        send(4'hD, 1'b1, 1'b0, 1'b1, 1'b1);
        drain();
        check_counts("rr", 3, 3);

        // MODE change mid-packet: packet stays round-robin (port 0), pointer then 1.
        send(4'h1, 1'b0, 1'b1, 1'b1, 1'b0);
        send(4'h3, 1'b1, 1'b1, 1'b0, 1'b0);
        send(4'h2, 1'b1, 1'b0, 1'b0, 1'b0);
        send(4'h4, 1'b1, 1'b0, 1'b1, 1'b1);
        drain();
        check_counts("mode_chg", 5, 4);

        // Backpressure on port 0: buffered beat held, IN_READY low.
        OUT0_READY = 1'b0;
        send(4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #2;
            check("bp_in_ready", int'(IN_READY), 0);
            check("bp_valid", int'(OUT0_VALID), 1);
            check("bp_data", int'(OUT0_DATA), 14);
            check("bp_busy", int'(BUSY), 1);
        end
        @(negedge CLK);
        OUT0_READY = 1'b1;
        send(4'hF, 1'b1, 1'b1, 1'b0, 1'b0);
        drain();
        check_counts("bp", 6, 4);

        // Reset in the middle of a stalled packet.
        OUT0_READY = 1'b0;
        send(4'h8, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        q0.delete();
        q1.delete();
        @(negedge CLK);
        RST = 1'b0;
        OUT0_READY = 1'b1;
        #2;
        check_idle("mid_reset");
        // Back in SOP: a port-1 single beat must not follow the old lock.
        send(4'h2, 1'b1, 1'b1, 1'b0, 1'b1);
        drain();
        check_counts("post_reset", 0, 1);

        // Counter wrap on port 0.
        for (int i = 0; i < 255; i++) begin
            send(4'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        drain();
        check_counts("cnt_255", 255, 1);
        send(4'h5, 1'b1, 1'b0, 1'b0, 1'b0);
        drain();
        check_counts("cnt_wrap", 0, 1);
        send(4'h6, 1'b1, 1'b0, 1'b0, 1'b0);
        drain();
        check_counts("cnt_after_wrap", 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_1x2_stream_ctrl.md
Name: demux_1x2_stream_ctrl

Overview:
- Packet-aware steering controller for a 1-to-2 demultiplexed stream with valid/ready handshakes.
- Chooses the destination port once per packet, either from a per-packet destination bit or by round-robin.
- Locks that choice until the packet's LAST beat.
- Sits between a single upstream producer and two downstream consumers; provides one registered output stage and per-port packet counters.

Parameters:
- WIDTH, 4, data beat width in bits.
- CNT_W, 8, width of the per-port packet counters.

Ports:
- CLK  input  1  clock; all logic is rising-edge.
- RST  input  1  synchronous, active-high reset.
- MODE  input  1  routing mode: 0 = route by IN_DEST, 1 = round-robin per packet.
- IN_DATA  input  WIDTH  upstream data beat.
- IN_VALID  input  1  upstream beat valid.
- IN_LAST  input  1  marks the final beat of a packet.
- IN_DEST  input  1  destination port for the packet; meaningful on the first beat only.
- IN_READY  output  1  controller can accept a beat this cycle.
- OUT0_DATA  output  WIDTH  port 0 data.
- OUT0_VALID  output  1  port 0 beat valid.
- OUT0_LAST  output  1  port 0 last beat.
- OUT0_READY  input  1  port 0 consumer ready.
- OUT1_DATA  output  WIDTH  port 1 data.
- OUT1_VALID  output  1  port 1 beat valid.
- OUT1_LAST  output  1  port 1 last beat.
- OUT1_READY  input  1  port 1 consumer ready.
- BUSY  output  1  high while a packet is in progress or the output stage holds a beat.
- PKT_CNT0  output  CNT_W  count of packets completed on port 0.
- PKT_CNT1  output  CNT_W  count of packets completed on port 1.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous, active-high, sampled on the CLK rising edge.
- Reset state:
  - state = SOP, rr_ptr = 0, lock_port = 0, output buffer empty.
  - All OUTx_VALID/LAST/DATA = 0.
  - BUSY = 0, PKT_CNT0 = PKT_CNT1 = 0.
- RST mid-packet: the partial packet is discarded, the buffered beat is dropped and the counters clear. The next accepted beat is treated as a start of packet.
- Handshake:
  - A beat is accepted when IN_VALID && IN_READY.
  - A beat is delivered on port p when OUTp_VALID && OUTp_READY.
- Output stage: one register entry holding data, last and port.
  - IN_READY = !buf_valid || (delivery of the buffered beat this cycle). This is combinational from OUTx_READY, giving full throughput of one beat per cycle.
  - Latency: an accepted beat appears on its output port on the next cycle.
- Inactive port: only the buffered beat's port drives VALID=1. The other port drives VALID=0, LAST=0, DATA=0. When the buffer is empty, both ports drive zeros.
- State machine:
  - SOP: waiting for the first beat of a packet. On acceptance:
    - port = MODE ? rr_ptr : IN_DEST, latched into lock_port.
    - If IN_LAST=1 (single-beat packet), stay in SOP; otherwise go to MID.
  - MID: every accepted beat goes to lock_port; IN_DEST and MODE are ignored. Acceptance with IN_LAST=1 returns to SOP.
- Round-robin:
  - rr_ptr toggles when a LAST beat is accepted and that packet was routed in round-robin mode.
  - rr_ptr is unchanged for IN_DEST-routed packets.
- Mode change: MODE is sampled only at SOP acceptance. A change mid-packet takes effect from the next packet.
- Backpressure:
  - A stalled destination holds the buffer. IN_READY stays 0 until that beat delivers.
  - The other port is not served meanwhile; this is strict in-order, with no bypass.
- Counters:
  - PKT_CNTp increments by 1 on delivery of a LAST beat on port p.
  - Counters wrap modulo 2^CNT_W (255 -> 0 at default). Both may not increment in the same cycle, since there is a single buffer.
- BUSY = (state == MID) || buf_valid.

Test Plan:
- Reset then idle:
  - Stimulus: RST=1 for 2 cycles, then IN_VALID=0.
  - Response: all outputs 0, IN_READY=1, BUSY=0.
- Dest routing, 3-beat packet:
  - Stimulus: MODE=0, IN_DEST=1, data 0x3, 0x5, 0x9 with LAST on 0x9, both READY=1.
  - Response: OUT1 shows 0x3, 0x5, 0x9 on cycles +1..+3 with OUT1_LAST on 0x9. OUT0_VALID stays 0. PKT_CNT1=1.
- IN_DEST ignored mid-packet:
  - Stimulus: MODE=0, first beat IN_DEST=0, second beat IN_DEST=1.
  - Response: both beats appear on OUT0 only.
- Round-robin:
  - Stimulus: MODE=1, four single-beat packets 0xA, 0xB, 0xC, 0xD.
  - Response: 0xA, 0xC on OUT0; 0xB, 0xD on OUT1. PKT_CNT0=2, PKT_CNT1=2.
- Backpressure:
  - Stimulus: OUT0_READY=0 for 3 cycles while a packet is routed to port 0.
  - Response: OUT0_DATA/VALID held stable, IN_READY=0. The beat delivers on the cycle OUT0_READY=1; no beat lost or duplicated.
- Mid-packet reset and counter wrap:
  - Stimulus: assert RST during MID.
  - Response: buffer and outputs cleared, state SOP, counters 0.
  - Stimulus: separately, deliver 256 packets to port 0.
  - Response: PKT_CNT0 wraps to 0.
